oscillator_sequencer: RTL and testbench

- Controller for the coupled spring-mass Euler oscillator datapath (18-bit 2.16 fixed point, x1/x2 outputs).
- Holds the oscillator in init while NIOS loads constants, then issues one integration step every step_period clocks.
- Scales each x1/x2 result into a VGA pixel and hands it to the frame-buffer writer over a valid/ready port.
- Advances the plot column 0..639, wrapping at the screen edge.

---
 rtl/oscillator_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_oscillator_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oscillator_sequencer.sv
// rtl/oscillator_sequencer.sv - step/plot sequencer for the coupled spring-mass Euler oscillator
module oscillator_sequencer #(
  parameter int WIDTH  = 18,
  parameter int XRES   = 640,
  parameter int YRES   = 480,
  parameter int YSHIFT = 9
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic             cfg_pause,
  input  logic [15:0]      step_period,
  output logic             osc_init,
  output logic             osc_step,
  input  logic             osc_done,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  output logic [9:0]       px_x,
  output logic [8:0]       px_y,
  output logic [1:0]       px_color,
  output logic             px_valid,
  input  logic             px_ready,
  output logic [9:0]       col,
  output logic [15:0]      wraps
);

  typedef enum logic [2:0] {S_INIT, S_WAIT, S_STEP, S_PLOT1, S_PLOT2} state_t;

  localparam logic signed [10:0] Y_MID  = 11'(YRES / 2);
  localparam logic signed [10:0] Y_MAX  = 11'(YRES - 1);
  localparam logic [9:0]         COL_MAX = 10'(XRES - 1);

  state_t           state_q, state_d;
  logic             init_cnt_q, init_cnt_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [9:0]       col_q, col_d;
  logic [15:0]      wraps_q, wraps_d;
  logic [WIDTH-1:0] x1_q, x1_d, x2_q, x2_d;
  logic             stepped_q, stepped_d;
  logic             load_pend_q, load_pend_d;
  logic [15:0]      period_m1;
  logic             restart;

  // Signed state value to screen row: centre at YRES/2, positive displacement goes up.
  function automatic logic [8:0] map_y(input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] sv;
    logic signed [10:0]      s;
    logic signed [10:0]      y;
    sv = $signed(v) >>> YSHIFT;
    s  = 11'(sv);
    y  = Y_MID - s;
    if (y < 11'sd0)
      y = 11'sd0;
    else if (y > Y_MAX)
      y = Y_MAX;
    return y[8:0];
  endfunction

  assign period_m1 = (step_period <= 16'd1) ? 16'd0 : step_period - 16'd1;
  assign col       = col_q;
  assign wraps     = wraps_q;

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q     <= S_INIT;
      init_cnt_q  <= 1'b0;
      cnt_q       <= 16'd0;
      col_q       <= 10'd0;
      wraps_q     <= 16'd0;
      x1_q        <= '0;
      x2_q        <= '0;
      stepped_q   <= 1'b0;
      load_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      wraps_q     <= wraps_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      stepped_q   <= stepped_d;
      load_pend_q <= load_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    wraps_d     = wraps_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    stepped_d   = stepped_q;
    load_pend_d = load_pend_q;
    restart     = 1'b0;
    osc_init    = 1'b0;
    osc_step    = 1'b0;
    px_valid    = 1'b0;
    px_x        = 10'd0;
    px_y        = 9'd0;
    px_color    = 2'b00;

    case (state_q)
      S_INIT: begin
        osc_init = 1'b1;
        if (cfg_load) begin
          restart = 1'b1;
        end else if (init_cnt_q) begin
          state_d    = S_WAIT;
          cnt_d      = period_m1;
          init_cnt_d = 1'b0;
        end else begin
          init_cnt_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (cfg_load) begin
          restart = 1'b1;
        end else if (!cfg_pause) begin
          if (cnt_q == 16'd0) begin
            state_d   = S_STEP;
            stepped_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
      end
      S_STEP: begin
        osc_step  = !stepped_q;
        stepped_d = 1'b1;
        // A load here drops the step outright, even if its done arrives this cycle.
        if (cfg_load) begin
          restart = 1'b1;
        end else if (osc_done) begin
          x1_d    = x1;
          x2_d    = x2;
          state_d = S_PLOT1;
        end
      end
      S_PLOT1: begin
        px_valid = 1'b1;
        px_x     = col_q;
        px_y     = map_y(x1_q);
        px_color = 2'b01;
        if (cfg_load)
          load_pend_d = 1'b1;
        if (px_ready) begin
          if (cfg_load || load_pend_q)
            restart = 1'b1;
          else
            state_d = S_PLOT2;
        end
      end
      S_PLOT2: begin
        px_valid = 1'b1;
        px_x     = col_q;
        px_y     = map_y(x2_q);
        px_color = 2'b10;
        if (cfg_load)
          load_pend_d = 1'b1;
        if (px_ready) begin
          if (cfg_load || load_pend_q) begin
            restart = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = period_m1;
            if (col_q == COL_MAX) begin
              col_d   = 10'd0;
              wraps_d = wraps_q + 16'd1;
            end else begin
              col_d = col_q + 10'd1;
            end
          end
        end
      end
      default: state_d = S_INIT;
    endcase

    if (restart) begin
      state_d     = S_INIT;
      init_cnt_d  = 1'b0;
      col_d       = 10'd0;
      wraps_d     = 16'd0;
      load_pend_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_oscillator_sequencer.sv
// tb/tb_oscillator_sequencer.sv - scoreboard bench for oscillator_sequencer
module tb_oscillator_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_load;
  logic        cfg_pause;
  logic [15:0] step_period;
  logic        osc_init;
  logic        osc_step;
  logic        osc_done;
  logic [17:0] x1;
  logic [17:0] x2;
  logic [9:0]  px_x;
  logic [8:0]  px_y;
  logic [1:0]  px_color;
  logic        px_valid;
  logic        px_ready;
  logic [9:0]  col;
  logic [15:0] wraps;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          step_cyc[$];
  logic [35:0] xq[$];
  logic [20:0] exp_q[$];

  oscillator_sequencer #(.WIDTH(18), .XRES(640), .YRES(480), .YSHIFT(9)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .cfg_load   (cfg_load),
    .cfg_pause  (cfg_pause),
    .step_period(step_period),
    .osc_init   (osc_init),
    .osc_step   (osc_step),
    .osc_done   (osc_done),
    .x1         (x1),
    .x2         (x2),
    .px_x       (px_x),
    .px_y       (px_y),
    .px_color   (px_color),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .col        (col),
    .wraps      (wraps)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (osc_step === 1'b1) step_cyc.push_back(cyc);

  // Oscillator stand-in: done one cycle after each step, x from the stimulus queue (0 if empty).
  initial begin
    logic stp;
    osc_done = 1'b0;
    x1 = '0;
    x2 = '0;
    forever begin
      @(negedge clk);
      stp = (osc_step === 1'b1);
      @(posedge clk);
      #1;
      osc_done = 1'b0;
      if (stp) begin
        if (xq.size() > 0) {x1, x2} = xq.pop_front();
        else {x1, x2} = '0;
        osc_done = 1'b1;
      end
    end
  end

  // Scoreboard monitor: every accepted pixel is popped and compared.
  always @(negedge clk) begin
    logic [20:0] e;
    if (px_valid === 1'b1 && px_ready === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pixel_unexpected: got x=%0d y=%0d c=%0d, required none", px_x, px_y, px_color);
      end else begin
        e = exp_q.pop_front();
        if ({px_x, px_y, px_color} !== e) begin
          n_bad++;
          $display("FAIL pixel: got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                   px_x, px_y, px_color, e[20:11], e[10:2], e[1:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_px(input int cx, input int y1, input int y2, input bit both);
    exp_q.push_back({10'(cx), 9'(y1), 2'b01});
    if (both) exp_q.push_back({10'(cx), 9'(y2), 2'b10});
  endtask

  // Returns how many cycles osc_init stayed high and the cycle it first read low (WAIT entry).
  task automatic measure_init(output int n, output int fall_cyc);
    int guard;
    n = 0;
    guard = 0;
    fall_cyc = 0;
    @(negedge clk);
    while (osc_init !== 1'b1 && guard < 30) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 30) chk("init_rise_timeout", 0, 1);
    while (osc_init === 1'b1 && n < 10) begin
      n++;
      @(negedge clk);
    end
    fall_cyc = cyc;
  endtask

  task automatic wait_steps(input int n, input int budget, input string nm);
    int g;
    g = 0;
    while (step_cyc.size() < n && g < budget) begin
      g++;
      tick();
    end
    if (g >= budget) chk(nm, 0, 1);
  endtask

  initial begin
    int ninit;
    int wentry;
    int g;
    int nsteps;
    reset       = 1'b0;
    cfg_load    = 1'b0;
    cfg_pause   = 1'b0;
    step_period = 16'd4;
    px_ready    = 1'b1;
    repeat (3) tick();

    chk("rst_osc_init", osc_init, 1);
    chk("rst_osc_step", osc_step, 0);
    chk("rst_px_valid", px_valid, 0);
    chk("rst_px_xyc", {px_x, px_y, px_color}, 0);
    chk("rst_col", col, 0);
    chk("rst_wraps", wraps, 0);

    xq.push_back({18'h3_8000, 18'h0_8000});
    push_px(0, 304, 176, 1);
    xq.push_back({18'h0_4000, 18'h3_C000});
    push_px(1, 208, 272, 1);
    xq.push_back({18'h1_FFFF, 18'h2_0000});
    push_px(2, 0, 479, 1);
    reset = 1'b1;

    measure_init(ninit, wentry);
    chk("init_cycles", ninit, 2);
    wait_steps(1, 20, "step1_timeout");
    chk("first_step_delay", step_cyc[0] - wentry, 4);
    wait_steps(2, 20, "step2_timeout");
    chk("step_spacing_1", step_cyc[1] - step_cyc[0], 8);
    chk("col_after_step1", col, 1);
    wait_steps(3, 20, "step3_timeout");
    chk("step_spacing_2", step_cyc[2] - step_cyc[1], 8);

    // Stall the third step's first pixel; period 0 applies from the next reload.
    px_ready    = 1'b0;
    step_period = 16'd0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", px_valid, 1);
      chk("stall_fields", {px_x, px_y, px_color}, {10'd2, 9'd0, 2'b01});
    end
    for (int c = 3; c < 640; c++) push_px(c, 240, 240, 1);
    px_ready = 1'b1;
    repeat (3) tick();
    chk("col_after_step3", col, 3);

    wait_steps(5, 40, "step5_timeout");
    chk("period0_spacing", step_cyc[4] - step_cyc[3], 5);

    g = 0;
    while (wraps !== 16'd1 && g < 5000) begin
      g++;
      tick();
    end
    if (g >= 5000) chk("wrap_timeout", 0, 1);
    cfg_pause = 1'b1;
    chk("wrap_col", col, 0);
    chk("wrap_count", wraps, 1);
    chk("wrap_pixels_drained", exp_q.size(), 0);
    chk("wrap_step_total", step_cyc.size(), 640);

    // Load while the first pixel waits on ready: that pixel lands, the second is dropped.
    px_ready    = 1'b0;
    step_period = 16'd10;
    push_px(0, 240, 0, 0);
    cfg_pause = 1'b0;
    g = 0;
    while (px_valid !== 1'b1 && g < 20) begin
      g++;
      tick();
    end
    if (g >= 20) chk("plot1_timeout", 0, 1);
    tick();
    tick();
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("load_plot1_held", {px_valid, px_color}, {1'b1, 2'b01});
    tick();
    tick();
    px_ready = 1'b1;
    measure_init(ninit, wentry);
    chk("load_init_cycles", ninit, 2);
    chk("load_col", col, 0);
    chk("load_wraps", wraps, 0);

    // Pause for 20 WAIT cycles of a 10-cycle period.
    xq.push_back({18'h0_8000, 18'h3_8000});
    push_px(0, 176, 304, 1);
    tick();
    tick();
    tick();
    nsteps = step_cyc.size();
    cfg_pause = 1'b1;
    repeat (20) tick();
    cfg_pause = 1'b0;
    chk("pause_no_step", step_cyc.size(), nsteps);
    wait_steps(nsteps + 1, 40, "pause_step_timeout");
    chk("pause_step_delay", step_cyc[nsteps] - wentry, 30);
    repeat (8) tick();
    chk("final_col", col, 1);
    chk("final_pixels_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
